// File: rtl/mvm_pkg.sv
// Shared widths, types and the requantisation function for the MVM post-processing path.
// Build option: define ACT_RELU_EN to clamp negative accumulators to zero before rounding.
package mvm_pkg;
  localparam int IN_W    = 28;
  localparam int OUT_W   = 14;
  localparam int OUT_MAX = 8191;
  localparam int OUT_MIN = -8192;

  typedef logic signed [IN_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0] act_t;

  typedef struct packed {
    act_t data;
    logic last;
  } act_word_t;

  // One extra bit of headroom keeps x + half-LSB from overflowing.
  function automatic act_t requant(input acc_t x, input int sh);
    acc_t                  xa;
    logic signed [IN_W:0]  r;
    logic signed [IN_W:0]  s;
    logic signed [IN_W:0]  one;
    xa  = x;
`ifdef ACT_RELU_EN
    if (x < 0) xa = '0;
`endif
    one = (IN_W+1)'(1);
    r   = {xa[IN_W-1], xa};
    if (sh > 0) r = r + (one <<< (sh - 1));
    s = r >>> sh;
    if (s > (IN_W+1)'(OUT_MAX))      return act_t'(OUT_MAX);
    else if (s < (IN_W+1)'(OUT_MIN)) return act_t'(OUT_MIN);
    else                             return act_t'(s[OUT_W-1:0]);
  endfunction
endpackage

// File: rtl/mvm_requant_stage_if.sv
// Valid/ready stream bundle: 28-bit accumulator in, 14-bit activation with vector-last out.
interface mvm_requant_stage_if;
  import mvm_pkg::*;
  logic input_valid;
  logic input_ready;
  acc_t input_data;
  logic output_valid;
  logic output_ready;
  act_t output_data;
  logic output_last;

  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_data, output_last
  );
  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_data, output_last
  );
endinterface

// File: rtl/mvm_requant_stage_act_fifo.sv
// Synchronous FIFO of requantised words; head is presented combinationally from storage.
module act_fifo
  import mvm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  act_word_t din,
  output logic      full,
  output logic      empty,
  output act_word_t dout
);
  localparam int AW = $clog2(DEPTH);

  act_word_t      r_mem [DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [AW:0]    r_cnt;
  logic           w_push, w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; contents behind an empty FIFO are don't-care.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end
endmodule

// File: rtl/mvm_requant_stage.sv
// Requantise the MVM y-stream to 14-bit activations, tag vector ends, and buffer in a FIFO.
// Build option: ACT_RELU_EN selects ReLU before rounding (see mvm_pkg::requant).
module mvm_requant_stage
  import mvm_pkg::*;
#(
  parameter int K     = 8,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  mvm_requant_stage_if.slave bus
);
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  logic [CW-1:0] r_vec_cnt;
  logic          w_full, w_empty, w_push, w_pop;
  act_word_t     w_din, w_dout;

  assign bus.input_ready  = !w_full && !reset;
  assign bus.output_valid = !w_empty;
  assign w_push           = bus.input_valid && bus.input_ready;
  assign w_pop            = bus.output_valid && bus.output_ready;

  assign w_din.data = requant(bus.input_data, SHIFT);
  assign w_din.last = (r_vec_cnt == CW'(K - 1));

  // Stale storage must not leak a last flag while nothing is valid.
  assign bus.output_data = w_dout.data;
  assign bus.output_last = w_dout.last && !w_empty;

  always_ff @(posedge clk) begin
    if (reset)       r_vec_cnt <= '0;
    else if (w_push) r_vec_cnt <= (r_vec_cnt == CW'(K - 1)) ? '0 : r_vec_cnt + 1'b1;
  end

  act_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_dout)
  );
endmodule

// File: tb/tb_mvm_requant_stage.sv
// Directed + randomised scoreboard bench for mvm_requant_stage (K=8, SHIFT=8, DEPTH=4).
module tb_mvm_requant_stage;
  import mvm_pkg::*;

  localparam int K     = 8;
  localparam int SHIFT = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  mvm_requant_stage_if bus();

  mvm_requant_stage #(.K(K), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [14:0] sb_q [$];
  int          last_pos [$];
  int          vcnt = 0;
  int          out_cnt = 0;
  bit          stall_prev = 0;
  logic [14:0] prev_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Independent reference using 64-bit integer arithmetic.
  function automatic logic [14:0] model(input logic signed [27:0] x, input bit last);
    longint v;
    v = longint'(x);
`ifdef ACT_RELU_EN
    if (v < 0) v = 0;
`endif
    if (SHIFT > 0) v = v + (longint'(1) << (SHIFT - 1));
    v = v >>> SHIFT;
    if (v > 8191)  v = 8191;
    if (v < -8192) v = -8192;
    return {14'(v), last};
  endfunction

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [14:0] cur, exp_w;
    cur = {bus.output_data, bus.output_last};
    if (reset) begin
      sb_q.delete();
      last_pos.delete();
      vcnt = 0;
      out_cnt = 0;
      stall_prev = 0;
    end else begin
      if (bus.output_valid) chk("xprop", 32'($isunknown(cur)), 32'd0);
      if (stall_prev) chk("stall_hold", {17'd0, cur}, {17'd0, prev_w});
      if (bus.output_valid && bus.output_ready) begin
        if (sb_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          exp_w = sb_q.pop_front();
          chk("data", {17'd0, cur}, {17'd0, exp_w});
        end
        if (bus.output_last) last_pos.push_back(out_cnt);
        out_cnt++;
      end
      if (bus.input_valid && bus.input_ready) begin
        sb_q.push_back(model(bus.input_data, vcnt == K - 1));
        vcnt = (vcnt + 1) % K;
      end
      stall_prev = bus.output_valid && !bus.output_ready;
      prev_w = cur;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic signed [27:0] x);
    int t;
    t = 0;
    bus.input_valid = 1'b1;
    bus.input_data  = x;
    while (!bus.input_ready && t < 200) begin step(); t++; end
    step();
    chk("send_timeout", 32'(t >= 200), 32'd0);
    bus.input_valid = 1'b0;
    bus.input_data  = 'x;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.output_ready = 1'b1;
    while (sb_q.size() != 0 && t < 200) begin step(); t++; end
    step();
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    bus.input_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int acc, t;
    logic signed [27:0] vec2 [5];
    bit hit;
    vec2 = '{-28'sd1000, 28'sd128, 28'sd127, 28'sd5000000, -28'sd5000000};

    reset = 1'b1;
    bus.input_valid  = 1'b0;
    bus.input_data   = 'x;
    bus.output_ready = 1'b0;
    step();
    chk("rst_in_ready", 32'(bus.input_ready), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(bus.input_ready), 32'd1);
    chk("post_rst_ovalid", 32'(bus.output_valid), 32'd0);
    chk("post_rst_olast", 32'(bus.output_last), 32'd0);

    // 1: single word, visible one cycle after acceptance
    bus.output_ready = 1'b1;
    send(28'sd1000);
    chk("t1_valid", 32'(bus.output_valid), 32'd1);
    chk("t1_word", {17'd0, bus.output_data, bus.output_last}, {17'd0, 14'sd4, 1'b0});

    // 2: rounding and saturation corners
    foreach (vec2[i]) send(vec2[i]);
    drain();

    // 3: fill with output stalled, then release
    pulse_reset();
    bus.output_ready = 1'b0;
    acc = 0;
    bus.input_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.input_data = 28'(acc * 40000 - 100000);
      hit = bus.input_ready;
      step();
      if (hit) acc++;
    end
    chk("t3_fill", 32'(acc), 32'd4);
    chk("t3_full_ready", 32'(bus.input_ready), 32'd0);
    chk("t3_full_valid", 32'(bus.output_valid), 32'd1);
    bus.output_ready = 1'b1;
    t = 0;
    while (acc < 16 && t < 100) begin
      bus.input_data = 28'(acc * 40000 - 100000);
      hit = bus.input_ready;
      step();
      if (hit) acc++;
      t++;
    end
    bus.input_valid = 1'b0;
    bus.input_data  = 'x;
    chk("t3_resume", 32'(acc), 32'd16);
    drain();

    // 4: three vectors back to back
    pulse_reset();
    bus.output_ready = 1'b1;
    for (int i = 0; i < 3 * K; i++) send(28'(i * 777 - 9000));
    drain();
    chk("t4_nlast", 32'(last_pos.size()), 32'd3);
    if (last_pos.size() == 3) begin
      chk("t4_last0", 32'(last_pos[0]), 32'd7);
      chk("t4_last1", 32'(last_pos[1]), 32'd15);
      chk("t4_last2", 32'(last_pos[2]), 32'd23);
    end

    // 5: reset with words buffered
    pulse_reset();
    bus.output_ready = 1'b1;
    send(28'sd300); send(28'sd600);
    drain();
    bus.output_ready = 1'b0;
    send(28'sd900); send(28'sd1200); send(28'sd1500);
    chk("t5_buffered", 32'(sb_q.size()), 32'd3);
    reset = 1'b1;
    step();
    chk("t5_rst_ovalid", 32'(bus.output_valid), 32'd0);
    chk("t5_rst_olast", 32'(bus.output_last), 32'd0);
    reset = 1'b0;
    bus.output_ready = 1'b1;
    for (int i = 0; i < K; i++) send(28'(i * 1000));
    drain();
    chk("t5_nlast", 32'(last_pos.size()), 32'd1);
    if (last_pos.size() == 1) chk("t5_last_pos", 32'(last_pos[0]), 32'd7);

    // 6: randomised handshakes
    acc = 0;
    t = 0;
    while (acc < 10000 && t < 60000) begin
      bus.output_ready = ($urandom_range(0, 3) != 0);
      bus.input_valid  = ($urandom_range(0, 3) != 0);
      if (!bus.input_valid) bus.input_data = 'x;
      else if ($urandom_range(0, 1) == 1) bus.input_data = 28'($urandom);
      else bus.input_data = 28'($signed($urandom_range(0, 140000)) - 70000);
      hit = bus.input_valid && bus.input_ready;
      step();
      if (hit) acc++;
      t++;
    end
    bus.input_valid = 1'b0;
    bus.input_data  = 'x;
    chk("t6_words", 32'(acc), 32'd10000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
